// File: rtl/inst_fetch_buffer_if.sv
// Bundle between the core, the instruction fetch buffer and the instruction ROM.
// Core side: cpu_valid_o/cpu_req_i is a valid/ready pair; a word moves only in a cycle where both are 1.
interface inst_fetch_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              cpu_req_i;
  logic              flush_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic              cpu_valid_o;
  logic [INST_W-1:0] cpu_inst_o;
  logic [ADDR_W-1:0] cpu_pc_o;
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;

  modport slave (
    input  cpu_req_i, flush_i, cpu_addr_i, rom_inst_i,
    output cpu_valid_o, cpu_inst_o, cpu_pc_o, rom_ce_o, rom_addr_o
  );

  modport master (
    output cpu_req_i, flush_i, cpu_addr_i, rom_inst_i,
    input  cpu_valid_o, cpu_inst_o, cpu_pc_o, rom_ce_o, rom_addr_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: credit-limited sequential prefetch from a fixed-latency ROM
// into a small FIFO, with epoch-tagged reads so that a redirect discards stale returns.
module inst_fetch_buffer #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                ROM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  inst_fetch_buffer_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SUM_W   = CNT_W + 1;
  // Wide enough that back-to-back redirects cannot wrap the epoch within ROM_LAT cycles.
  localparam int EPOCH_W = 3;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic [INST_W-1:0]  inst_mem_q  [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic               tag_vld_q   [ROM_LAT];
  logic [ADDR_W-1:0]  tag_pc_q    [ROM_LAT];
  logic [EPOCH_W-1:0] tag_epoch_q [ROM_LAT];

  logic empty;
  logic credit_ok;
  logic issue;
  logic ret_vld;
  logic wr_en;
  logic pop;

  always_comb begin
    empty     = (count_q == '0);
    credit_ok = ({1'b0, count_q} + {1'b0, inflight_q}) < SUM_W'(DEPTH);
    issue     = !rst && !bus.flush_i && credit_ok;
    ret_vld   = tag_vld_q[ROM_LAT-1];
    wr_en     = ret_vld && (tag_epoch_q[ROM_LAT-1] == epoch_q) && !bus.flush_i;
    pop       = !empty && !bus.flush_i && bus.cpu_req_i;
  end

  // Every returning read frees its credit, including ones dropped for a stale epoch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret_vld);
    if (bus.flush_i) begin
      fetch_pc_d = bus.cpu_addr_i;
      epoch_d    = epoch_q + EPOCH_W'(1);
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_vld_q[i] <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      tag_vld_q[0] <= issue;
      for (int i = 1; i < ROM_LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  // Payload of the tag pipe and FIFO storage; qualified by the valid bits above.
  always_ff @(posedge clk) begin
    tag_pc_q[0]    <= fetch_pc_q;
    tag_epoch_q[0] <= epoch_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_pc_q[i]    <= tag_pc_q[i-1];
      tag_epoch_q[i] <= tag_epoch_q[i-1];
    end
    if (wr_en) begin
      inst_mem_q[wr_ptr_q] <= bus.rom_inst_i;
      pc_mem_q[wr_ptr_q]   <= tag_pc_q[ROM_LAT-1];
    end
  end

  assign bus.rom_ce_o    = issue;
  assign bus.rom_addr_o  = fetch_pc_q;
  assign bus.cpu_valid_o = !empty && !bus.flush_i;
  assign bus.cpu_inst_o  = empty ? '0 : inst_mem_q[rd_ptr_q];
  assign bus.cpu_pc_o    = empty ? '0 : pc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer: one instance with a 1-cycle ROM at PC 0, one with a 3-cycle ROM
// starting near the top of the address space; each ROM word is its address XOR a constant.
module tb_inst_fetch_buffer;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam logic [AW-1:0] K = 32'h5A5A_5A5A;
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_0000_0000;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int ce_cnt;
  logic [AW-1:0] exp_a[$];
  logic [AW-1:0] exp_b[$];
  logic [AW-1:0] mon_a_pc;
  logic [AW-1:0] mon_b_pc;

  // clock / reset
  always #5 clk = ~clk;

  inst_fetch_buffer_if #(.ADDR_W(AW), .INST_W(IW)) ifa ();
  inst_fetch_buffer_if #(.ADDR_W(AW), .INST_W(IW)) ifb ();

  inst_fetch_buffer #(.ADDR_W(AW), .INST_W(IW), .DEPTH(4), .ROM_LAT(1), .RESET_PC(32'h0))
    dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  inst_fetch_buffer #(.ADDR_W(AW), .INST_W(IW), .DEPTH(4), .ROM_LAT(3), .RESET_PC(32'hFFFF_FFF8))
    dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  // ROM models
  logic [AW-1:0] rom_a_q;
  logic [AW-1:0] rom_b_q [3];
  always @(posedge clk) begin
    rom_a_q    <= ifa.rom_addr_o;
    rom_b_q[0] <= ifb.rom_addr_o;
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
  end
  assign ifa.rom_inst_i = rom_a_q ^ K;
  assign ifb.rom_inst_i = rom_b_q[2] ^ K;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_exp_a(input logic [AW-1:0] start);
    exp_a.delete();
    for (int i = 0; i < 64; i++) exp_a.push_back(start + AW'(4 * i));
  endtask

  task automatic fill_exp_b(input logic [AW-1:0] start);
    exp_b.delete();
    for (int i = 0; i < 64; i++) exp_b.push_back(start + AW'(4 * i));
  endtask

  task automatic chk_reset_a();
    chk("a_rst_ce",    64'(ifa.rom_ce_o),    64'(0));
    chk("a_rst_addr",  64'(ifa.rom_addr_o),  64'(0));
    chk("a_rst_valid", 64'(ifa.cpu_valid_o), 64'(0));
    chk("a_rst_inst",  64'(ifa.cpu_inst_o),  64'(0));
    chk("a_rst_pc",    64'(ifa.cpu_pc_o),    64'(0));
  endtask

  // scoreboards: every accepted instruction is checked against the head of the expected queue
  always @(negedge clk) begin
    if (!rst_a && ifa.cpu_valid_o && ifa.cpu_req_i) begin
      if (exp_a.size() == 0) chk("a_extra_pop", 64'(ifa.cpu_pc_o), NONE);
      else begin
        mon_a_pc = exp_a.pop_front();
        chk("a_pc",   64'(ifa.cpu_pc_o),   64'(mon_a_pc));
        chk("a_inst", 64'(ifa.cpu_inst_o), 64'(mon_a_pc ^ K));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && ifb.cpu_valid_o && ifb.cpu_req_i) begin
      if (exp_b.size() == 0) chk("b_extra_pop", 64'(ifb.cpu_pc_o), NONE);
      else begin
        mon_b_pc = exp_b.pop_front();
        chk("b_pc",   64'(ifb.cpu_pc_o),   64'(mon_b_pc));
        chk("b_inst", 64'(ifb.cpu_inst_o), 64'(mon_b_pc ^ K));
      end
    end
  end

  initial begin
    ifa.cpu_req_i = 1'b1; ifa.flush_i = 1'b0; ifa.cpu_addr_i = '0;
    ifb.cpu_req_i = 1'b0; ifb.flush_i = 1'b0; ifb.cpu_addr_i = '0;

    // streaming at one instruction per cycle from reset
    tick(); tick();
    #1; chk_reset_a();
    fill_exp_a(32'h0);
    rst_a = 1'b0;
    #1;
    chk("a_c0_ce",    64'(ifa.rom_ce_o),    64'(1));
    chk("a_c0_addr",  64'(ifa.rom_addr_o),  64'(0));
    chk("a_c0_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_c1_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_c2_valid", 64'(ifa.cpu_valid_o), 64'(1));
    for (int i = 0; i < 8; i++) begin
      tick(); #1; chk("a_nogap_valid", 64'(ifa.cpu_valid_o), 64'(1));
    end

    // core stalls: credits cap the prefetch at DEPTH reads
    rst_a = 1'b1;
    tick();
    fill_exp_a(32'h0);
    rst_a = 1'b0;
    ifa.cpu_req_i = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (ifa.rom_ce_o) ce_cnt++;
      tick();
    end
    chk("a_stall_ce_count", 64'(ce_cnt), 64'(4));
    #1;
    chk("a_stall_valid", 64'(ifa.cpu_valid_o), 64'(1));
    chk("a_stall_pc",    64'(ifa.cpu_pc_o),    64'(0));
    chk("a_stall_inst",  64'(ifa.cpu_inst_o),  64'(K));
    ifa.cpu_req_i = 1'b1;
    repeat (5) tick();
    ifa.cpu_req_i = 1'b0;
    #1;
    chk("a_release_count", 64'(exp_a.size()),  64'(59));
    chk("a_release_valid", 64'(ifa.cpu_valid_o), 64'(1));
    chk("a_release_head",  64'(ifa.cpu_pc_o),    64'(20));

    // flush together with a request on a non-empty FIFO
    repeat (3) tick();
    #1; chk("a_pre_flush_valid", 64'(ifa.cpu_valid_o), 64'(1));
    ifa.flush_i = 1'b1; ifa.cpu_req_i = 1'b1; ifa.cpu_addr_i = 32'h200;
    fill_exp_a(32'h200);
    #1;
    chk("a_flush_valid", 64'(ifa.cpu_valid_o), 64'(0));
    chk("a_flush_ce",    64'(ifa.rom_ce_o),    64'(0));
    tick();
    ifa.flush_i = 1'b0;
    #1;
    chk("a_redir_ce",    64'(ifa.rom_ce_o),    64'(1));
    chk("a_redir_addr",  64'(ifa.rom_addr_o),  64'(32'h200));
    chk("a_redir_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_redir_f2_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_redir_f3_valid", 64'(ifa.cpu_valid_o), 64'(1));
    repeat (3) tick();

    // back-to-back flushes: the second target wins
    ifa.flush_i = 1'b1; ifa.cpu_addr_i = 32'h300;
    fill_exp_a(32'h300);
    tick();
    ifa.cpu_addr_i = 32'h400;
    fill_exp_a(32'h400);
    #1; chk("a_b2b_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick();
    ifa.flush_i = 1'b0;
    #1;
    chk("a_b2b_ce",   64'(ifa.rom_ce_o),   64'(1));
    chk("a_b2b_addr", 64'(ifa.rom_addr_o), 64'(32'h400));
    tick(); #1; chk("a_b2b_f3_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_b2b_f4_valid", 64'(ifa.cpu_valid_o), 64'(1));
    repeat (3) tick();

    // reset pulse in the middle of streaming
    rst_a = 1'b1;
    tick();
    #1; chk_reset_a();
    fill_exp_a(32'h0);
    rst_a = 1'b0;
    #1;
    chk("a_rerst_ce",   64'(ifa.rom_ce_o),   64'(1));
    chk("a_rerst_addr", 64'(ifa.rom_addr_o), 64'(0));
    tick(); #1; chk("a_rerst_c1_valid", 64'(ifa.cpu_valid_o), 64'(0));
    tick(); #1; chk("a_rerst_c2_valid", 64'(ifa.cpu_valid_o), 64'(1));
    repeat (4) tick();

    // address wrap with a 3-cycle ROM
    ifb.cpu_req_i = 1'b1;
    fill_exp_b(32'hFFFF_FFF8);
    rst_b = 1'b0;
    #1;
    chk("b_c0_ce",   64'(ifb.rom_ce_o),   64'(1));
    chk("b_c0_addr", 64'(ifb.rom_addr_o), 64'(32'hFFFF_FFF8));
    tick(); #1; chk("b_c1_addr", 64'(ifb.rom_addr_o), 64'(32'hFFFF_FFFC));
    tick(); #1; chk("b_c2_addr", 64'(ifb.rom_addr_o), 64'(32'h0));
    tick(); #1; chk("b_c3_valid", 64'(ifb.cpu_valid_o), 64'(0));
    tick(); #1; chk("b_c4_valid", 64'(ifb.cpu_valid_o), 64'(1));
    repeat (8) tick();

    // redirect while three reads are in flight
    rst_b = 1'b1;
    tick();
    exp_b.delete();
    rst_b = 1'b0;
    repeat (3) tick();
    ifb.flush_i = 1'b1; ifb.cpu_addr_i = 32'h100;
    fill_exp_b(32'h100);
    #1;
    chk("b_flush_ce",    64'(ifb.rom_ce_o),    64'(0));
    chk("b_flush_valid", 64'(ifb.cpu_valid_o), 64'(0));
    tick();
    ifb.flush_i = 1'b0;
    #1;
    chk("b_redir_ce",    64'(ifb.rom_ce_o),    64'(1));
    chk("b_redir_addr",  64'(ifb.rom_addr_o),  64'(32'h100));
    chk("b_redir_valid", 64'(ifb.cpu_valid_o), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick(); #1; chk("b_redir_wait_valid", 64'(ifb.cpu_valid_o), 64'(0));
    end
    tick(); #1; chk("b_redir_first_valid", 64'(ifb.cpu_valid_o), 64'(1));
    repeat (6) tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
